// File: rtl/condicionador_botoes.sv
// Push-button conditioner for the memory game: per-button synchroniser and debounce filter,
// followed by a small FSM that accepts one valid press per push-release cycle.
module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_in,
    input  logic                limpa,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_feita,
    output logic                erro_multiplo,
    output logic                db_tem_jogada,
    output logic [1:0]          db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    // The increment that would reach DEBOUNCE_CICLOS is the one that commits the new level.
    localparam logic [CW-1:0] CNT_ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'b00,
        REGISTRA      = 2'b01,
        ESPERA_SOLTAR = 2'b10
    } estado_t;

    logic [N_BOTOES-1:0] deb_reg;
    logic [N_BOTOES-1:0] deb_next;
    estado_t             estado_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_BOTOES; gi++) begin : g_botao
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic [CW-1:0]          cnt_next;
            logic                   deb_bit_reg;
            logic                   deb_bit_next;
            logic                   sync_bit;

            assign sync_bit = sync_reg[SYNC_STAGES-1];

            always_comb begin
                cnt_next     = '0;
                deb_bit_next = deb_bit_reg;
                if (sync_bit != deb_bit_reg) begin
                    if (cnt_reg == CNT_ULTIMO) begin
                        deb_bit_next = sync_bit;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_reg    <= '0;
                    cnt_reg     <= '0;
                    deb_bit_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], botoes_in[gi]};
                    cnt_reg     <= cnt_next;
                    deb_bit_reg <= deb_bit_next;
                end
            end

            assign deb_reg[gi]  = deb_bit_reg;
            assign deb_next[gi] = deb_bit_next;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg    <= OCIOSO;
            jogada        <= '0;
            jogada_feita  <= 1'b0;
            erro_multiplo <= 1'b0;
            db_tem_jogada <= 1'b0;
        end else begin
            jogada_feita  <= 1'b0;
            erro_multiplo <= 1'b0;
            db_tem_jogada <= |deb_next;
            // A later assignment in the OCIOSO accept branch overrides this clear.
            if (limpa) begin
                jogada <= '0;
            end
            case (estado_reg)
                REGISTRA: begin
                    estado_reg <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (deb_reg == '0) begin
                        estado_reg <= OCIOSO;
                    end
                end
                default: begin
                    if ($onehot(deb_reg)) begin
                        estado_reg   <= REGISTRA;
                        jogada       <= deb_reg;
                        jogada_feita <= 1'b1;
                    end else if (deb_reg != '0) begin
                        estado_reg    <= ESPERA_SOLTAR;
                        erro_multiplo <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign db_estado = estado_reg;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Randomized and directed bench for condicionador_botoes against a history-based reference model.
module tb_condicionador_botoes;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int SS = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] botoes_in = '0;
    logic         limpa = 1'b0;
    logic [N-1:0] jogada;
    logic         jogada_feita;
    logic         erro_multiplo;
    logic         db_tem_jogada;
    logic [1:0]   db_estado;

    condicionador_botoes #(
        .N_BOTOES       (N),
        .DEBOUNCE_CICLOS(D),
        .SYNC_STAGES    (SS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes_in    (botoes_in),
        .limpa        (limpa),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .erro_multiplo(erro_multiplo),
        .db_tem_jogada(db_tem_jogada),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronised samples all disagree with it.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_deb;
    logic [N-1:0] m_jog;
    bit           m_feita;
    bit           m_erro;
    int           m_fase;   // 0 idle, 1 just accepted, 2 waiting for full release

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SS + D; k++) hist.push_back('0);
        m_deb = '0; m_jog = '0; m_feita = 0; m_erro = 0; m_fase = 0;
    endtask

    task automatic model_step(input logic [N-1:0] raw, input logic lim);
        logic [N-1:0] old_deb;
        logic [N-1:0] new_deb;
        int           nset;
        old_deb = m_deb;
        for (int i = 0; i < N; i++) begin
            bit all_diff = 1;
            for (int k = SS; k < SS + D; k++)
                if (hist[hist.size() - k][i] == old_deb[i]) all_diff = 0;
            new_deb[i] = all_diff ? ~old_deb[i] : old_deb[i];
        end
        nset = $countones(old_deb);
        m_feita = 0;
        m_erro  = 0;
        if (lim) m_jog = '0;
        case (m_fase)
            0: if (nset == 1) begin m_jog = old_deb; m_feita = 1; m_fase = 1; end
               else if (nset > 1) begin m_erro = 1; m_fase = 2; end
            1: m_fase = 2;
            default: if (old_deb == '0) m_fase = 0;
        endcase
        m_deb = new_deb;
        hist.push_back(raw);
        if (hist.size() > SS + D) void'(hist.pop_front());
    endtask

    int edge_no     = 0;
    int pulses      = 0;
    int first_pulse = -1;

    task automatic mark();
        edge_no = 0; pulses = 0; first_pulse = -1;
    endtask

    // One clock: model follows the posedge, outputs compared on the following negedge.
    task automatic cycle();
        @(posedge clock);
        if (reset) model_step(botoes_in, limpa);
        else       model_reset();
        @(negedge clock);
        check("jogada",        32'(jogada),        32'(m_jog));
        check("jogada_feita",  32'(jogada_feita),  32'(m_feita));
        check("erro_multiplo", 32'(erro_multiplo), 32'(m_erro));
        check("db_tem_jogada", 32'(db_tem_jogada), 32'(|m_deb));
        check("db_estado",     32'(db_estado),     32'(m_fase));
        if (jogada_feita) begin
            pulses++;
            if (first_pulse < 0) first_pulse = edge_no;
        end
        edge_no++;
    endtask

    task automatic hold(input logic [N-1:0] val, input int n);
        botoes_in = val;
        repeat (n) cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_jogada", 32'(jogada), 32'h0);
        check("reset_estado", 32'(db_estado), 32'h0);
        reset = 1'b1;
        hold(4'b0000, 3);

        // 1: clean press, pulse only after edge 6
        mark();
        hold(4'b0100, 20);
        check("t1_first_pulse", 32'(first_pulse), 32'd6);
        check("t1_pulses", 32'(pulses), 32'd1);
        check("t1_jogada", 32'(jogada), 32'h4);
        hold(4'b0000, 10);
        check("t1_estado_release", 32'(db_estado), 32'h0);

        // 2: bounce then hold
        mark();
        for (int t = 0; t < 5; t++) begin
            hold(4'b0010, 2);
            hold(4'b0000, 2);
        end
        check("t2_no_pulse_bounce", 32'(pulses), 32'd0);
        hold(4'b0010, 12);
        check("t2_pulses", 32'(pulses), 32'd1);
        check("t2_jogada", 32'(jogada), 32'h2);
        hold(4'b0000, 10);

        // 3: short glitch
        mark();
        hold(4'b0001, 3);
        hold(4'b0000, 10);
        check("t3_pulses", 32'(pulses), 32'd0);
        check("t3_jogada", 32'(jogada), 32'h2);

        // 4: double press, then single
        mark();
        hold(4'b1001, 12);
        check("t4_no_pulse", 32'(pulses), 32'd0);
        check("t4_jogada", 32'(jogada), 32'h2);
        hold(4'b0000, 10);
        hold(4'b1000, 12);
        check("t4_pulses", 32'(pulses), 32'd1);
        check("t4_jogada2", 32'(jogada), 32'h8);
        hold(4'b0000, 10);

        // 5: hold + second button, limpa alone, limpa coinciding with accept
        mark();
        hold(4'b0001, 12);
        hold(4'b0101, 12);
        hold(4'b0100, 4);
        check("t5_one_pulse", 32'(pulses), 32'd1);
        hold(4'b0000, 10);
        limpa = 1'b1;
        cycle();
        limpa = 1'b0;
        check("t5_limpa", 32'(jogada), 32'h0);
        hold(4'b0010, 6);
        limpa = 1'b1;
        cycle();
        limpa = 1'b0;
        check("t5_accept_jogada", 32'(jogada), 32'h2);
        check("t5_accept_pulse", 32'(jogada_feita), 32'h1);
        hold(4'b0010, 4);
        hold(4'b0000, 10);

        // 6: reset while held in ESPERA_SOLTAR
        hold(4'b0100, 12);
        check("t6_estado_pre", 32'(db_estado), 32'h2);
        reset = 1'b0;
        #1;
        check("t6_rst_jogada", 32'(jogada), 32'h0);
        check("t6_rst_estado", 32'(db_estado), 32'h0);
        check("t6_rst_tem", 32'(db_tem_jogada), 32'h0);
        model_reset();
        repeat (3) cycle();
        reset = 1'b1;
        mark();
        hold(4'b0100, 15);
        check("t6_first_pulse", 32'(first_pulse), 32'd6);
        check("t6_pulses", 32'(pulses), 32'd1);
        hold(4'b0000, 10);

        // Random segments with occasional limpa and reset
        for (int s = 0; s < 120; s++) begin
            int r = $urandom_range(0, 99);
            logic [N-1:0] v;
            if (r < 45)      v = '0;
            else if (r < 85) v = N'(1) << $urandom_range(0, N - 1);
            else             v = N'($urandom);
            limpa = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                cycle();
                reset = 1'b1;
            end
            hold(v, $urandom_range(1, 9));
            limpa = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
